// File: rtl/urv_mult_pipe_if.sv
// Request/response bundle between an issue stage and the RV-M multiply pipe.
// Latency: none, this is a pure signal bundle.
// Backpressure: valid/ready on both sides; kill_i flushes everything in flight.
interface urv_mult_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  // Request side.
  logic             valid_i;
  logic             ready_o;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [2:0]       fun_i;
  logic [TAG_W-1:0] tag_i;
  logic             kill_i;
  // Result side.
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  rd_o;
  logic [TAG_W-1:0] tag_o;

  // Issue stage / consumer view.
  modport master (
    output valid_i, rs1_i, rs2_i, fun_i, tag_i, kill_i, ready_i,
    input  ready_o, valid_o, rd_o, tag_o
  );

  // Multiplier view.
  modport slave (
    input  valid_i, rs1_i, rs2_i, fun_i, tag_i, kill_i, ready_i,
    output ready_o, valid_o, rd_o, tag_o
  );
endinterface

// File: rtl/urv_mult_pipe.sv
// Two-stage RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU; divide codes return 0).
// Latency: result visible two edges after the request is presented, one op per cycle.
// Backpressure: ready_o = S1 empty | S2 empty | ready_i; stages hold while the consumer stalls.
module urv_mult_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  urv_mult_pipe_if.slave   bus
);

  // Stage occupancy; these are the only bits with control meaning.
  logic r_s1_vld;
  logic r_s2_vld;

  // S1 holds operands already extended to XLEN+1 bits so the multiplier is one signed array.
  logic [XLEN:0]      r_s1_a;
  logic [XLEN:0]      r_s1_b;
  logic [2:0]         r_s1_fun;
  logic [TAG_W-1:0]   r_s1_tag;

  // S2 holds the selected result.
  logic [XLEN-1:0]    r_s2_rd;
  logic [TAG_W-1:0]   r_s2_tag;

  logic               w_s2_en;
  logic               w_s1_en;
  logic               w_a_sx;
  logic               w_b_sx;
  logic [XLEN:0]      w_a_ext;
  logic [XLEN:0]      w_b_ext;
  logic [2*XLEN-1:0]  w_a_wide;
  logic [2*XLEN-1:0]  w_b_wide;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_rd;

  // S2 takes a new entry when it is empty or its result leaves this cycle;
  // S1 takes a new entry when it is empty or drains into S2.
  assign w_s2_en = ~r_s2_vld | bus.ready_i;
  assign w_s1_en = ~r_s1_vld | w_s2_en;

  // rs1 is signed for MULH and MULHSU, rs2 only for MULH.
  assign w_a_sx  = (bus.fun_i == 3'b001) | (bus.fun_i == 3'b010);
  assign w_b_sx  = (bus.fun_i == 3'b001);
  assign w_a_ext = {w_a_sx & bus.rs1_i[XLEN-1], bus.rs1_i};
  assign w_b_ext = {w_b_sx & bus.rs2_i[XLEN-1], bus.rs2_i};

  // Sign-extending both (XLEN+1)-bit operands to 2*XLEN makes a plain 2*XLEN-bit
  // multiply produce exactly the low 2*XLEN bits of the signed product.
  assign w_a_wide = {{(XLEN-1){r_s1_a[XLEN]}}, r_s1_a};
  assign w_b_wide = {{(XLEN-1){r_s1_b[XLEN]}}, r_s1_b};
  assign w_prod   = w_a_wide * w_b_wide;

  // Pick the low or high product half; divide codes (fun[2]=1) yield zero.
  always_comb begin
    w_rd = '0;
    if (!r_s1_fun[2]) begin
      if (r_s1_fun[1:0] == 2'b00) begin
        w_rd = w_prod[XLEN-1:0];
      end else begin
        w_rd = w_prod[2*XLEN-1:XLEN];
      end
    end
  end

  // Stage valids: kill empties both stages and drops the request offered alongside it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else if (bus.kill_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_s2_en) begin
        r_s2_vld <= r_s1_vld;
      end
      if (w_s1_en) begin
        r_s1_vld <= bus.valid_i;
      end
    end
  end

  // S1 payload: captured only on an accepted request, otherwise held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_fun <= '0;
      r_s1_tag <= '0;
    end else if (w_s1_en && bus.valid_i && !bus.kill_i) begin
      r_s1_a   <= w_a_ext;
      r_s1_b   <= w_b_ext;
      r_s1_fun <= bus.fun_i;
      r_s1_tag <= bus.tag_i;
    end
  end

  // S2 payload: captured only when a valid S1 entry advances, so a stalled result stays stable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_rd  <= '0;
      r_s2_tag <= '0;
    end else if (w_s2_en && r_s1_vld && !bus.kill_i) begin
      r_s2_rd  <= w_rd;
      r_s2_tag <= r_s1_tag;
    end
  end

  assign bus.ready_o = w_s1_en;
  assign bus.valid_o = r_s2_vld;
  assign bus.rd_o    = r_s2_rd;
  assign bus.tag_o   = r_s2_tag;

endmodule

// File: tb/tb_urv_mult_pipe.sv
// Self-checking bench for urv_mult_pipe: directed cases plus random traffic vs an arithmetic model.
// Latency: model expects a result two cycles after its request is accepted.
// Backpressure: random ready_i stalls; model derives ready_o from the number of ops in flight.
module tb_urv_mult_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  urv_mult_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
  urv_mult_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

  urv_mult_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (if32.slave)
  );

  urv_mult_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (if64.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;

  typedef struct {
    logic [63:0] val;
    int          k;
  } exp_t;

  exp_t        q[$];
  logic [63:0] outs[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the operands as the ISA defines them.
  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'b000:  p = ua * ub;
      3'b001:  p = sa * sb;
      3'b010:  p = sa * longint'(ub);
      3'b011:  p = ua * ub;
      default: p = '0;
    endcase
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [63:0] ref64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa;
    logic [127:0] sb;
    logic [127:0] ua;
    logic [127:0] ub;
    logic [127:0] p;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    case (f)
      3'b000:  p = ua * ub;
      3'b001:  p = sa * sb;
      3'b010:  p = sa * ub;
      3'b011:  p = ua * ub;
      default: p = '0;
    endcase
    return (f == 3'b000) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(4, 0))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic drv(input logic v, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] t);
    if32.valid_i = v;
    if32.fun_i   = f;
    if32.rs1_i   = a;
    if32.rs2_i   = b;
    if32.tag_i   = t;
  endtask

  // One clock of the 32-bit DUT: inputs are already driven, check at negedge, advance model.
  task automatic step();
    bit exp_v;
    @(negedge clk);
    exp_v = (q.size() > 0) && (cyc >= q[0].k + 2);
    chk("ready_o", 64'(if32.ready_o), 64'((q.size() < 2) || if32.ready_i));
    chk("valid_o", 64'(if32.valid_o), 64'(exp_v));
    if (exp_v && if32.valid_o) begin
      chk("result", {27'b0, if32.tag_o, if32.rd_o}, q[0].val);
      if (if32.ready_i) begin
        outs.push_back({27'b0, if32.tag_o, if32.rd_o});
        void'(q.pop_front());
      end
    end
    if (if32.kill_i) begin
      q.delete();
    end else if (if32.valid_i && if32.ready_o) begin
      q.push_back('{val: {27'b0, if32.tag_i, ref32(if32.fun_i, if32.rs1_i, if32.rs2_i)}, k: cyc});
      n_acc++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic op64(input string tag, input logic [2:0] f, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp);
    if64.valid_i = 1'b1;
    if64.fun_i   = f;
    if64.rs1_i   = a;
    if64.rs2_i   = b;
    if64.tag_i   = t;
    @(posedge clk);
    #1;
    if64.valid_i = 1'b0;
    chk({tag, "_early"}, 64'(if64.valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 64'(if64.valid_o), 64'd1);
    chk(tag, if64.rd_o, exp);
    chk({tag, "_tag"}, 64'(if64.tag_o), 64'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    int          base;
    logic [63:0] a64;
    logic [63:0] b64;

    rst_n         = 1'b0;
    drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    if32.kill_i   = 1'b0;
    if32.ready_i  = 1'b1;
    if64.valid_i  = 1'b0;
    if64.fun_i    = 3'b000;
    if64.rs1_i    = '0;
    if64.rs2_i    = '0;
    if64.tag_i    = '0;
    if64.kill_i   = 1'b0;
    if64.ready_i  = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(if32.valid_o), 64'd0);
    chk("rst_rd_o", 64'(if32.rd_o), 64'd0);
    chk("rst_tag_o", 64'(if32.tag_o), 64'd0);
    rst_n = 1'b1;
    step();

    // MUL 3 * -2, tag 7.
    outs.delete();
    drv(1'b1, 3'b000, 32'd3, 32'hFFFF_FFFE, 5'd7);
    step();
    drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    repeat (3) step();
    chk("mul_cnt", 64'(outs.size()), 64'd1);
    chk("mul_val", outs[0], {27'b0, 5'd7, 32'hFFFF_FFFA});

    // Back-to-back high-half products.
    outs.delete();
    drv(1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
    step();
    drv(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    step();
    drv(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    step();
    drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    repeat (3) step();
    chk("b2b_cnt", 64'(outs.size()), 64'd3);
    chk("mulh", outs[0], {27'b0, 5'd1, 32'h4000_0000});
    chk("mulhu", outs[1], {27'b0, 5'd2, 32'hFFFF_FFFE});
    chk("mulhsu", outs[2], {27'b0, 5'd3, 32'hFFFF_FFFF});

    // Backpressure: four ops offered against a stalled consumer.
    outs.delete();
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    base         = n_acc;
    if32.ready_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 6) begin
        chk("bp_accepted", 64'(n_acc - base), 64'd2);
        chk("bp_ready_low", 64'(if32.ready_o), 64'd0);
        if32.ready_i = 1'b1;
      end
      if (n_acc - base < 4) begin
        drv(1'b1, 3'(n_acc - base), bp_a[n_acc - base], bp_b[n_acc - base], 5'(10 + n_acc - base));
      end else begin
        drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      end
      step();
    end
    chk("bp_cnt", 64'(outs.size()), 64'd4);

    // Kill with two ops in flight and a third offered in the kill cycle.
    outs.delete();
    if32.ready_i = 1'b0;
    drv(1'b1, 3'b000, 32'd5, 32'd6, 5'd20);
    step();
    drv(1'b1, 3'b001, 32'd7, 32'd8, 5'd21);
    step();
    drv(1'b1, 3'b011, 32'd9, 32'd9, 5'd22);
    if32.kill_i = 1'b1;
    step();
    if32.kill_i  = 1'b0;
    if32.ready_i = 1'b1;
    drv(1'b1, 3'b000, 32'd11, 32'd12, 5'd23);
    step();
    drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    repeat (3) step();
    chk("kill_cnt", 64'(outs.size()), 64'd1);
    chk("kill_next", outs[0], {27'b0, 5'd23, 32'd132});

    // Asynchronous reset with both stages occupied.
    outs.delete();
    if32.ready_i = 1'b0;
    drv(1'b1, 3'b000, 32'd2, 32'd3, 5'd4);
    step();
    drv(1'b1, 3'b000, 32'd4, 32'd5, 5'd5);
    step();
    drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    chk("pre_rst_valid", 64'(if32.valid_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_o", 64'(if32.valid_o), 64'd0);
    chk("arst_rd_o", 64'(if32.rd_o), 64'd0);
    chk("arst_tag_o", 64'(if32.tag_o), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    if32.ready_i = 1'b1;
    repeat (4) step();
    chk("arst_cnt", 64'(outs.size()), 64'd0);

    // Random traffic with stalls and occasional kills.
    for (int c = 0; c < 400; c++) begin
      drv(1'($urandom_range(9, 0) < 7), 3'($urandom_range(7, 0)), pick32(), pick32(), 5'($urandom_range(31, 0)));
      if32.ready_i = 1'($urandom_range(9, 0) < 6);
      if32.kill_i  = 1'($urandom_range(49, 0) == 0);
      step();
    end
    drv(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    if32.kill_i  = 1'b0;
    if32.ready_i = 1'b1;
    repeat (4) step();
    chk("rand_drain", 64'(q.size()), 64'd0);

    // 64-bit instance.
    op64("mulhu64", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, 64'd1);
    op64("div64", 3'b100, 64'h1234_5678_9ABC_DEF0, 64'd3, 5'd10, 64'd0);
    op64("mulh64", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0);
    op64("mulhsu64", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      op64("rand64", 3'(i), a64, b64, 5'(i), ref64(3'(i), a64, b64));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
